// File: rtl/sprite_rom_arbiter.sv
// Shares one synchronous sprite ROM read port among NUM_REQ units, tagging reads for return.
// Define SPRITE_ROM_ARB_FIXED_PRIO_EN for fixed priority (index 0 highest) instead of round-robin.

module sprite_rom_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADDR_W  = 14,
  parameter int unsigned DATA_W  = 12,
  parameter int unsigned ROM_LAT = 2
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      frame_start,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] addr_in,
  output logic [NUM_REQ-1:0]        gnt,
  output logic                      rom_en,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic [DATA_W-1:0]         rom_data,
  output logic [DATA_W-1:0]         rd_data,
  output logic [NUM_REQ-1:0]        rd_valid
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]             gnt_q;
  logic [NUM_REQ-1:0]             rd_valid_q;
  logic [NUM_REQ-1:0]             eligible;
  logic [NUM_REQ-1:0]             win_onehot;
  logic                           rom_en_q;
  logic [ADDR_W-1:0]              rom_addr_q;
  logic [ADDR_W-1:0]              win_addr;
  logic [DATA_W-1:0]              rd_data_q;
  logic [ROM_LAT:0][NUM_REQ-1:0]  tag_q;
  logic                           win;
  logic [IdxW-1:0]                win_idx;

  // The requester seeing gnt this cycle still shows its old address, so it sits out.
  assign eligible = req & ~gnt_q;

`ifdef SPRITE_ROM_ARB_FIXED_PRIO_EN
  logic unused_frame_start;
  assign unused_frame_start = frame_start;

  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        win     = 1'b1;
        win_idx = IdxW'(i);
      end
    end
  end
`else
  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] ptr_d;
  logic [IdxW-1:0] cand;

  always_comb begin
    win     = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = IdxW'((ptr_q + off) % NUM_REQ);
      if (!win && eligible[cand]) begin
        win     = 1'b1;
        win_idx = cand;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (win) begin
      ptr_d = (win_idx == IdxW'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
    end
    // Frame start overrides the post-grant advance.
    if (frame_start) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  always_comb begin
    win_onehot = '0;
    if (win) begin
      win_onehot = NUM_REQ'(1) << win_idx;
    end
    win_addr = addr_in[win_idx*ADDR_W +: ADDR_W];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q      <= '0;
      rom_en_q   <= 1'b0;
      rom_addr_q <= '0;
      tag_q      <= '0;
      rd_valid_q <= '0;
      rd_data_q  <= '0;
    end else begin
      gnt_q      <= win_onehot;
      rom_en_q   <= win;
      if (win) begin
        rom_addr_q <= win_addr;
      end
      tag_q      <= {tag_q[ROM_LAT-1:0], win_onehot};
      rd_valid_q <= tag_q[ROM_LAT];
      rd_data_q  <= rom_data;
    end
  end

  assign gnt      = gnt_q;
  assign rom_en   = rom_en_q;
  assign rom_addr = rom_addr_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter (default round-robin build) with a latency-2 ROM model.

module tb_sprite_rom_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 14;
  localparam int DW   = 12;
  localparam int LAT  = 2;

  localparam logic [AW-1:0] A0   = 14'h0123;
  localparam logic [AW-1:0] A1   = 14'h0456;
  localparam logic [AW-1:0] A2   = 14'h1789;
  localparam logic [AW-1:0] A3   = 14'h2ABC;
  localparam logic [AW-1:0] BASE = 14'h0800;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              frame_start;
  logic [NREQ-1:0]   req;
  logic [NREQ*AW-1:0] addr_in;
  logic [NREQ-1:0]   gnt;
  logic              rom_en;
  logic [AW-1:0]     rom_addr;
  logic [DW-1:0]     rom_data;
  logic [DW-1:0]     rd_data;
  logic [NREQ-1:0]   rd_valid;

  int checks   = 0;
  int failures = 0;

  sprite_rom_arbiter #(
    .NUM_REQ(NREQ),
    .ADDR_W (AW),
    .DATA_W (DW),
    .ROM_LAT(LAT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .frame_start(frame_start),
    .req        (req),
    .addr_in    (addr_in),
    .gnt        (gnt),
    .rom_en     (rom_en),
    .rom_addr   (rom_addr),
    .rom_data   (rom_data),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_f(input logic [AW-1:0] a);
    logic [AW-1:0] t;
    t = a * 14'd5;
    return t[DW-1:0] ^ 12'hA53;
  endfunction

  // Synchronous ROM: word for the enabled address appears LAT cycles later.
  logic [DW-1:0] rom_pipe [LAT];
  always @(posedge clk) begin
    rom_pipe[0] <= rom_en ? rom_f(rom_addr) : '0;
    for (int i = 1; i < LAT; i++) rom_pipe[i] <= rom_pipe[i-1];
  end
  assign rom_data = rom_pipe[LAT-1];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic set_addr(input int i, input logic [AW-1:0] a);
    addr_in[i*AW +: AW] = a;
  endtask

  typedef struct {
    logic            fs;
    logic [NREQ-1:0] rq;
    logic [NREQ-1:0] eg;
    logic            en;
    logic [AW-1:0]   ra;
    logic [NREQ-1:0] rv;
    logic [AW-1:0]   rd_a;
  } vec_t;

  vec_t tbl [17];

  initial begin
    // Single read, frame_start re-aims ptr at 0, then req=1111 round-robin with a
    // frame_start landing on the grant to index 2.
    tbl[0]  = '{1'b0, 4'b0001, 4'b0001, 1'b1, A0, 4'b0000, A0};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, A0, 4'b0000, A0};
    tbl[2]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, A0, 4'b0000, A0};
    tbl[3]  = '{1'b1, 4'b0000, 4'b0000, 1'b0, A0, 4'b0001, A0};
    tbl[4]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, A0, 4'b0000, A0};
    tbl[5]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, A1, 4'b0000, A0};
    tbl[6]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, A2, 4'b0000, A0};
    tbl[7]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, A3, 4'b0001, A0};
    tbl[8]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, A0, 4'b0010, A1};
    tbl[9]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, A1, 4'b0100, A2};
    tbl[10] = '{1'b1, 4'b1111, 4'b0100, 1'b1, A2, 4'b1000, A3};
    tbl[11] = '{1'b0, 4'b1111, 4'b0001, 1'b1, A0, 4'b0001, A0};
    tbl[12] = '{1'b0, 4'b1111, 4'b0010, 1'b1, A1, 4'b0010, A1};
    tbl[13] = '{1'b0, 4'b0000, 4'b0000, 1'b0, A1, 4'b0100, A2};
    tbl[14] = '{1'b0, 4'b0000, 4'b0000, 1'b0, A1, 4'b0001, A0};
    tbl[15] = '{1'b0, 4'b0000, 4'b0000, 1'b0, A1, 4'b0010, A1};
    tbl[16] = '{1'b0, 4'b0000, 4'b0000, 1'b0, A1, 4'b0000, A0};

    reset_n     = 1'b1;
    frame_start = 1'b0;
    req         = '0;
    addr_in     = '0;
    #1 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_gnt", 32'(gnt), 32'h0);
    chk("reset_rom_en", 32'(rom_en), 32'h0);
    chk("reset_rom_addr", 32'(rom_addr), 32'h0);
    chk("reset_rd_valid", 32'(rd_valid), 32'h0);
    chk("reset_rd_data", 32'(rd_data), 32'h0);
    @(negedge clk) reset_n = 1'b1;

    set_addr(0, A0);
    set_addr(1, A1);
    set_addr(2, A2);
    set_addr(3, A3);

    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      frame_start = tbl[i].fs;
      req         = tbl[i].rq;
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_gnt", i), 32'(gnt), 32'(tbl[i].eg));
      chk($sformatf("tbl%0d_rom_en", i), 32'(rom_en), 32'(tbl[i].en));
      chk($sformatf("tbl%0d_rom_addr", i), 32'(rom_addr), 32'(tbl[i].ra));
      chk($sformatf("tbl%0d_rd_valid", i), 32'(rd_valid), 32'(tbl[i].rv));
      if (tbl[i].rv != '0) chk($sformatf("tbl%0d_rd_data", i), 32'(rd_data), 32'(rom_f(tbl[i].rd_a)));
    end
    frame_start = 1'b0;

    // Requester 2 alone, new address presented in each gnt cycle.
    for (int j = 0; j < 14; j++) begin
      logic [NREQ-1:0] eg;
      logic [AW-1:0]   ea;
      @(negedge clk);
      req = (j < 10) ? 4'b0100 : 4'b0000;
      set_addr(2, BASE + AW'((j + 1) / 2));
      @(posedge clk);
      #1;
      eg = (j < 10 && j % 2 == 0) ? 4'b0100 : 4'b0000;
      ea = BASE + AW'((j < 10) ? j / 2 : 4);
      chk($sformatf("solo%0d_gnt", j), 32'(gnt), 32'(eg));
      chk($sformatf("solo%0d_rom_en", j), 32'(rom_en), 32'(eg[2]));
      chk($sformatf("solo%0d_rom_addr", j), 32'(rom_addr), 32'(ea));
      if (j >= 3 && (j - 3) % 2 == 0 && j - 3 < 10) begin
        chk($sformatf("solo%0d_rd_valid", j), 32'(rd_valid), 32'h4);
        chk($sformatf("solo%0d_rd_data", j), 32'(rd_data), 32'(rom_f(BASE + AW'((j - 3) / 2))));
      end else begin
        chk($sformatf("solo%0d_rd_valid", j), 32'(rd_valid), 32'h0);
      end
    end

    // Two reads in flight, then a one-cycle reset pulse discards them.
    set_addr(2, A2);
    @(negedge clk) req = 4'b0011;
    @(posedge clk);
    #1 chk("flight0_gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1 chk("flight1_gnt", 32'(gnt), 32'h2);
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    #1;
    chk("midreset_gnt", 32'(gnt), 32'h0);
    chk("midreset_rom_en", 32'(rom_en), 32'h0);
    chk("midreset_rom_addr", 32'(rom_addr), 32'h0);
    chk("midreset_rd_valid", 32'(rd_valid), 32'h0);
    chk("midreset_rd_data", 32'(rd_data), 32'h0);
    @(negedge clk) reset_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("postrst%0d_rd_valid", k), 32'(rd_valid), 32'h0);
      chk($sformatf("postrst%0d_gnt", k), 32'(gnt), 32'h0);
    end

    // ptr is back at 0: index 0 beats index 3, then 3 follows.
    for (int k = 0; k < 6; k++) begin
      logic [NREQ-1:0] eg;
      logic [NREQ-1:0] ev;
      @(negedge clk);
      req = (k == 0) ? 4'b1001 : (k == 1) ? 4'b1000 : 4'b0000;
      @(posedge clk);
      #1;
      eg = (k == 0) ? 4'b0001 : (k == 1) ? 4'b1000 : 4'b0000;
      ev = (k == 3) ? 4'b0001 : (k == 4) ? 4'b1000 : 4'b0000;
      chk($sformatf("after%0d_gnt", k), 32'(gnt), 32'(eg));
      chk($sformatf("after%0d_rd_valid", k), 32'(rd_valid), 32'(ev));
      if (k == 0) chk("after0_rom_addr", 32'(rom_addr), 32'(A0));
      if (k == 1) chk("after1_rom_addr", 32'(rom_addr), 32'(A3));
      if (k == 3) chk("after3_rd_data", 32'(rd_data), 32'(rom_f(A0)));
      if (k == 4) chk("after4_rd_data", 32'(rd_data), 32'(rom_f(A3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
